// File: rtl/sar_conv_sequencer.sv
// SAR conversion sequencer: scans masked channels, tracks/samples each one, then runs a
// NUM_BITS binary search on dac_code from cmp_in and posts results to a 1-entry output register.
module sar_conv_sequencer #(
  parameter int unsigned NUM_BITS      = 8,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_ready,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                cmp_in,
  output logic                sample_en,
  output logic [CH_W-1:0]     ch_sel,
  output logic [NUM_BITS-1:0] dac_code,
  output logic                busy,
  output logic [NUM_BITS-1:0] data,
  output logic [CH_W-1:0]     data_ch,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                overrun
);

  localparam int unsigned K_W  = $clog2(NUM_BITS);
  localparam int unsigned SC_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                mode_q, mode_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [SC_W-1:0]     cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_sel_d, data_ch_d, nxt_ch;
  logic [NUM_BITS-1:0] dac_d, data_d, trial;
  logic                sample_en_d, busy_d, valid_d, overrun_d, found;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--)
      if (m[i]) lowest_set = CH_W'(i);
  endfunction

  // State and output registers
  always_ff @(posedge clk_ready) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      mode_q     <= 1'b0;
      k_q        <= '0;
      cnt_q      <= '0;
      sample_en  <= 1'b0;
      ch_sel     <= '0;
      dac_code   <= '0;
      busy       <= 1'b0;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      sample_en  <= sample_en_d;
      ch_sel     <= ch_sel_d;
      dac_code   <= dac_d;
      busy       <= busy_d;
      data       <= data_d;
      data_ch    <= data_ch_d;
      data_valid <= valid_d;
      overrun    <= overrun_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    sample_en_d = sample_en;
    ch_sel_d    = ch_sel;
    dac_d       = dac_code;
    data_d      = data;
    data_ch_d   = data_ch;
    valid_d     = data_valid;
    overrun_d   = overrun;
    trial       = dac_code;
    found       = 1'b0;
    nxt_ch      = '0;

    if (data_valid && data_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        sample_en_d = 1'b0;
        dac_d       = '0;
        if (start && (|ch_mask)) begin
          mask_d      = ch_mask;
          mode_d      = mode;
          ch_sel_d    = lowest_set(ch_mask);
          cnt_d       = '0;
          sample_en_d = 1'b1;
          state_d     = SAMPLE;
        end
      end

      SAMPLE: begin
        dac_d = '0;
        if (cnt_q == SC_W'(SAMPLE_CYCLES - 1)) begin
          sample_en_d = 1'b0;
          dac_d       = NUM_BITS'(1) << (NUM_BITS - 1);
          k_d         = K_W'(NUM_BITS - 1);
          state_d     = CONVERT;
        end else begin
          cnt_d = cnt_q + SC_W'(1);
        end
      end

      CONVERT: begin
        if (!cmp_in) trial[k_q] = 1'b0;
        if (k_q != '0) begin
          trial[k_q - K_W'(1)] = 1'b1;
          k_d   = k_q - K_W'(1);
          dac_d = trial;
        end else begin
          data_d    = trial;
          data_ch_d = ch_sel;
          valid_d   = 1'b1;
          if (data_valid && !data_ready) overrun_d = 1'b1;
          dac_d     = '0;
          // Next enabled channel above the current one; wrap only in continuous mode
          for (int i = int'(NUM_CH) - 1; i >= 0; i--)
            if (mask_q[i] && (CH_W'(i) > ch_sel)) begin
              found  = 1'b1;
              nxt_ch = CH_W'(i);
            end
          if (mode_q) begin
            if (!found) nxt_ch = lowest_set(mask_q);
            found = start;
          end
          if (found) begin
            ch_sel_d    = nxt_ch;
            cnt_d       = '0;
            sample_en_d = 1'b1;
            state_d     = SAMPLE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a comparator model and a result scoreboard.
module tb_sar_conv_sequencer;

  logic       clk_ready = 1'b0;
  logic       reset, start, mode, cmp_in, data_ready;
  logic [3:0] ch_mask;
  logic       sample_en, busy, data_valid, overrun;
  logic [1:0] ch_sel, data_ch;
  logic [7:0] dac_code, data;
  logic [7:0] vin [4];

  typedef struct packed {logic [1:0] ch; logic [7:0] d;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  sar_conv_sequencer #(.NUM_BITS(8), .NUM_CH(4), .SAMPLE_CYCLES(2)) dut (
    .clk_ready(clk_ready), .reset(reset), .start(start), .mode(mode), .ch_mask(ch_mask),
    .cmp_in(cmp_in), .sample_en(sample_en), .ch_sel(ch_sel), .dac_code(dac_code),
    .busy(busy), .data(data), .data_ch(data_ch), .data_valid(data_valid),
    .data_ready(data_ready), .overrun(overrun)
  );

  always #5 clk_ready = ~clk_ready;

  always_comb cmp_in = (vin[ch_sel] >= dac_code);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic m, input logic [3:0] mask);
    mode    = m;
    ch_mask = mask;
    start   = 1'b1;
    @(negedge clk_ready);
    if (!m) start = 1'b0;
  endtask

  task automatic push_ch(input int c);
    exp_t e;
    e.ch = 2'(c);
    e.d  = vin[c];
    sb.push_back(e);
  endtask

  // Wait for data_valid, pop the scoreboard and compare; reports cycles waited
  task automatic wait_result(input string tag, input int exp_n);
    int   n = 0;
    exp_t e;
    bit   seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk_ready);
      n++;
      if (data_valid) seen = 1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(n), 32'(exp_n));
      check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_data"}, 32'(data), 32'(e.d));
        check({tag, "_ch"}, 32'(data_ch), 32'(e.ch));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_sample_en"}, 32'(sample_en), 0);
    check({tag, "_dac"}, 32'(dac_code), 0);
    check({tag, "_data"}, 32'(data), 0);
    check({tag, "_data_ch"}, 32'(data_ch), 0);
    check({tag, "_ch_sel"}, 32'(ch_sel), 0);
    check({tag, "_valid"}, 32'(data_valid), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    logic [7:0] dac_exp [8];
    dac_exp = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vin = '{8'h00, 8'h00, 8'h00, 8'h00};
    reset = 1'b1; start = 1'b0; mode = 1'b0; ch_mask = '0; data_ready = 1'b1;
    repeat (2) @(negedge clk_ready);
    check_reset_state("rst");
    reset = 1'b0;

    // 1: single channel, trace the binary search
    vin[0] = 8'hA5;
    push_ch(0);
    kick(1'b0, 4'b0001);
    check("t1_sample_e0", 32'(sample_en), 1);
    check("t1_busy_e0", 32'(busy), 1);
    check("t1_dac_e0", 32'(dac_code), 0);
    @(negedge clk_ready);
    check("t1_sample_e1", 32'(sample_en), 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_ready);
      check($sformatf("t1_dac_e%0d", k + 2), 32'(dac_code), 32'(dac_exp[k]));
      check($sformatf("t1_sample_off_e%0d", k + 2), 32'(sample_en), 0);
      check($sformatf("t1_valid_early_e%0d", k + 2), 32'(data_valid), 0);
    end
    wait_result("t1", 1);
    check("t1_busy_after", 32'(busy), 0);
    @(negedge clk_ready);
    check("t1_valid_clear", 32'(data_valid), 0);

    // 2: two channels in one single scan, extreme codes
    vin[1] = 8'h00; vin[3] = 8'hFF;
    push_ch(1); push_ch(3);
    kick(1'b0, 4'b1010);
    check("t2_ch_sel", 32'(ch_sel), 1);
    wait_result("t2a", 10);
    check("t2_busy_mid", 32'(busy), 1);
    wait_result("t2b", 10);
    check("t2_busy_end", 32'(busy), 0);
    repeat (12) @(negedge clk_ready);
    check("t2_no_extra", 32'(data_valid), 0);

    // 3: continuous round robin, stop during ch2 conversion
    vin[1] = 8'h3C; vin[2] = 8'hC3;
    push_ch(1); push_ch(2); push_ch(1); push_ch(2);
    kick(1'b1, 4'b0110);
    wait_result("t3a", 10);
    wait_result("t3b", 10);
    wait_result("t3c", 10);
    repeat (5) @(negedge clk_ready);
    check("t3_ch_sel_mid", 32'(ch_sel), 2);
    start = 1'b0;
    wait_result("t3d", 5);
    check("t3_busy_end", 32'(busy), 0);
    repeat (12) @(negedge clk_ready);
    check("t3_no_extra", 32'(data_valid), 0);
    check("t3_sb_empty", 32'(sb.size()), 0);

    // 4a: unread result overwritten -> overrun
    vin[0] = 8'h11; vin[1] = 8'h22;
    data_ready = 1'b0;
    kick(1'b0, 4'b0011);
    repeat (10) @(negedge clk_ready);
    check("t4_valid1", 32'(data_valid), 1);
    check("t4_data1", 32'(data), 32'h11);
    check("t4_ovr1", 32'(overrun), 0);
    repeat (10) @(negedge clk_ready);
    check("t4_ovr2", 32'(overrun), 1);
    check("t4_data2", 32'(data), 32'h22);
    check("t4_ch2", 32'(data_ch), 1);
    data_ready = 1'b1;
    @(negedge clk_ready);
    check("t4_valid_clear", 32'(data_valid), 0);
    check("t4_ovr_sticky", 32'(overrun), 1);

    // 4b: consumer accepts on the load edge -> no overrun
    reset = 1'b1;
    @(negedge clk_ready);
    reset = 1'b0;
    data_ready = 1'b0;
    kick(1'b0, 4'b0011);
    repeat (10) @(negedge clk_ready);
    check("t4b_data1", 32'(data), 32'h11);
    repeat (9) @(negedge clk_ready);
    data_ready = 1'b1;
    @(negedge clk_ready);
    check("t4b_ovr", 32'(overrun), 0);
    check("t4b_valid", 32'(data_valid), 1);
    check("t4b_data2", 32'(data), 32'h22);
    @(negedge clk_ready);
    check("t4b_valid_clear", 32'(data_valid), 0);

    // 5: reset mid-conversion, then start with an empty mask
    vin[2] = 8'h77;
    kick(1'b0, 4'b0100);
    repeat (5) @(negedge clk_ready);
    check("t5_busy_pre", 32'(busy), 1);
    check("t5_ch_sel_pre", 32'(ch_sel), 2);
    reset = 1'b1;
    @(negedge clk_ready);
    reset = 1'b0;
    check_reset_state("t5_rst");
    ch_mask = 4'b0000;
    start   = 1'b1;
    @(negedge clk_ready);
    check("t5_mask0_busy", 32'(busy), 0);
    repeat (12) @(negedge clk_ready);
    check("t5_mask0_busy_late", 32'(busy), 0);
    check("t5_no_result", 32'(data_valid), 0);
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
